// File: rtl/pa_fdsu_iter_pkg.sv
// Shared types and constants for the iterative divide/sqrt engine.
package pa_fdsu_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic {
    MODE_DIV  = 1'b0,
    MODE_SQRT = 1'b1
  } mode_t;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

endpackage

// File: rtl/pa_fdsu_iter_step.sv
// One radix-2 restoring iteration, shared by divide and square root.
module pa_fdsu_iter_step #(
  parameter int WIDTH = 24
) (
  input  logic             i_sqrt,
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic [1:0]       i_rad_bits,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quot
);

  localparam int HALF = WIDTH / 2;
  localparam int RW   = WIDTH + 1;

  // Two guard bits above R keep the shifted partial remainder exact in both modes.
  logic [WIDTH+2:0] w_part;
  logic [WIDTH+2:0] w_trial;
  logic             w_ge;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_trial = '0;
    if (i_sqrt) begin
      w_part              = {i_rem, i_rad_bits};
      w_trial[HALF+1:0]   = {i_quot[HALF-1:0], 2'b01};
    end else begin
      w_part              = {1'b0, i_rem, i_quot[WIDTH-1]};
      w_trial[WIDTH-1:0]  = i_divisor;
    end
    w_ge   = (w_part >= w_trial);
    o_rem  = RW'(w_ge ? (w_part - w_trial) : w_part);
    o_quot = {i_quot[WIDTH-2:0], w_ge};
  end

endmodule

// File: rtl/pa_fdsu_iter.sv
// Multi-cycle integer divide / square-root engine with EX1 issue and frbus write-back.
module pa_fdsu_iter
  import pa_fdsu_iter_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int FREG_W = 5
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              ex1_start_vld,
  input  logic              ex1_start_sqrt,
  input  logic [WIDTH-1:0]  ex1_src0,
  input  logic [WIDTH-1:0]  ex1_src1,
  input  logic [FREG_W-1:0] ex1_dst_freg,
  output logic              ex1_start_rdy,
  output logic              ex1_stall,
  input  logic              flush,
  output logic              no_op,
  output logic              wb_vld,
  input  logic              wb_grant,
  output logic [WIDTH-1:0]  wb_quot,
  output logic [WIDTH-1:0]  wb_rem,
  output logic [FREG_W-1:0] wb_freg,
  output logic [4:0]        wb_fflags
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t              r_state;
  state_t              w_state_nxt;
  mode_t               r_mode;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH:0]      r_rem;
  logic [WIDTH-1:0]    r_quot;
  logic [WIDTH-1:0]    r_src0;
  logic [WIDTH-1:0]    r_src1;
  logic [FREG_W-1:0]   r_freg;

  logic                r_wb_vld;
  logic [WIDTH-1:0]    r_wb_quot;
  logic [WIDTH-1:0]    r_wb_rem;
  logic [FREG_W-1:0]   r_wb_freg;
  logic [4:0]          r_wb_fflags;

  logic                w_accept;
  logic                w_last;
  logic [1:0]          w_rad_bits;
  logic [WIDTH:0]      w_rem_nxt;
  logic [WIDTH-1:0]    w_quot_nxt;
  logic                w_dz;
  logic [4:0]          w_fflags;

  assign ex1_start_rdy = (r_state == ST_IDLE);
  assign no_op         = (r_state == ST_IDLE);
  assign ex1_stall     = ex1_start_vld & ~ex1_start_rdy;

  assign w_accept   = (r_state == ST_IDLE) && ex1_start_vld && !flush;
  assign w_last     = (r_state == ST_CALC) && (r_cnt == '0);
  // Radicand pairs are consumed MSB first, so the pair index follows the countdown.
  assign w_rad_bits = 2'(r_src0 >> {r_cnt, 1'b0});

  pa_fdsu_iter_step #(.WIDTH(WIDTH)) u_step (
    .i_sqrt     (r_mode == MODE_SQRT),
    .i_rem      (r_rem),
    .i_quot     (r_quot),
    .i_divisor  (r_src1),
    .i_rad_bits (w_rad_bits),
    .o_rem      (w_rem_nxt),
    .o_quot     (w_quot_nxt)
  );

  always_comb begin
    w_dz               = (r_mode == MODE_DIV) && (r_src1 == '0);
    w_fflags           = '0;
    w_fflags[FF_DZ]    = w_dz;
    w_fflags[FF_NX]    = !w_dz && (w_rem_nxt != '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)        w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == '0)     w_state_nxt = ST_WB;
      ST_WB:   if (wb_grant)        w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_DIV;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_src0      <= '0;
      r_src1      <= '0;
      r_freg      <= '0;
      r_wb_vld    <= 1'b0;
      r_wb_quot   <= '0;
      r_wb_rem    <= '0;
      r_wb_freg   <= '0;
      r_wb_fflags <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wb_vld <= (w_state_nxt == ST_WB);
      if (w_accept) begin
        r_mode <= ex1_start_sqrt ? MODE_SQRT : MODE_DIV;
        r_cnt  <= ex1_start_sqrt ? CNT_W'(WIDTH/2 - 1) : CNT_W'(WIDTH - 1);
        r_rem  <= '0;
        r_quot <= ex1_start_sqrt ? '0 : ex1_src0;
        r_src0 <= ex1_src0;
        r_src1 <= ex1_src1;
        r_freg <= ex1_dst_freg;
      end else if (r_state == ST_CALC) begin
        r_rem  <= w_rem_nxt;
        r_quot <= w_quot_nxt;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (w_last && !flush) begin
        r_wb_quot   <= w_quot_nxt;
        r_wb_rem    <= w_rem_nxt[WIDTH-1:0];
        r_wb_freg   <= r_freg;
        r_wb_fflags <= w_fflags;
      end
    end
  end

  assign wb_vld    = r_wb_vld;
  assign wb_quot   = r_wb_quot;
  assign wb_rem    = r_wb_rem;
  assign wb_freg   = r_wb_freg;
  assign wb_fflags = r_wb_fflags;

endmodule

// File: tb/tb_pa_fdsu_iter.sv
// Directed plus randomized checks of pa_fdsu_iter (WIDTH=8) against an arithmetic model.
module tb_pa_fdsu_iter;

  localparam int W  = 8;
  localparam int FW = 5;

  logic          forever_cpuclk = 1'b0;
  logic          cpurst_b       = 1'b0;
  logic          ex1_start_vld  = 1'b0;
  logic          ex1_start_sqrt = 1'b0;
  logic [W-1:0]  ex1_src0       = '0;
  logic [W-1:0]  ex1_src1       = '0;
  logic [FW-1:0] ex1_dst_freg   = '0;
  logic          flush          = 1'b0;
  logic          wb_grant       = 1'b0;
  logic          ex1_start_rdy, ex1_stall, no_op, wb_vld;
  logic [W-1:0]  wb_quot, wb_rem;
  logic [FW-1:0] wb_freg;
  logic [4:0]    wb_fflags;

  int n_checks = 0;
  int n_errors = 0;

  pa_fdsu_iter #(.WIDTH(W), .FREG_W(FW)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .ex1_start_vld  (ex1_start_vld),
    .ex1_start_sqrt (ex1_start_sqrt),
    .ex1_src0       (ex1_src0),
    .ex1_src1       (ex1_src1),
    .ex1_dst_freg   (ex1_dst_freg),
    .ex1_start_rdy  (ex1_start_rdy),
    .ex1_stall      (ex1_stall),
    .flush          (flush),
    .no_op          (no_op),
    .wb_vld         (wb_vld),
    .wb_grant       (wb_grant),
    .wb_quot        (wb_quot),
    .wb_rem         (wb_rem),
    .wb_freg        (wb_freg),
    .wb_fflags      (wb_fflags)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  // Reference: plain integer arithmetic, floor sqrt by search.
  task automatic model(input bit sq, input int a, input int b,
                       output int q, output int r, output int f);
    int root;
    if (sq) begin
      root = 0;
      while ((root + 1) * (root + 1) <= a) root++;
      q = root;
      r = a - root * root;
      f = (r != 0) ? 1 : 0;
    end else if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      f = 8;
    end else begin
      q = a / b;
      r = a % b;
      f = (r != 0) ? 1 : 0;
    end
  endtask

  task automatic start(input bit sq, input int a, input int b, input int tag);
    ex1_start_vld  = 1'b1;
    ex1_start_sqrt = sq;
    ex1_src0       = W'(a);
    ex1_src1       = W'(b);
    ex1_dst_freg   = FW'(tag);
    step();
    ex1_start_vld  = 1'b0;
  endtask

  // Called in the cycle after the acceptance edge.
  task automatic finish(input bit sq, input int a, input int b, input int tag, input int gdly);
    int lat, q, r, f;
    lat = 1;
    while (!wb_vld && lat < 40) begin
      step();
      lat++;
    end
    model(sq, a, b, q, r, f);
    check("latency", lat, sq ? (W/2 + 1) : (W + 1));
    check("quot", wb_quot, q);
    check("rem", wb_rem, r);
    check("freg", wb_freg, tag);
    check("fflags", wb_fflags, f);
    repeat (gdly) begin
      step();
      check("hold_vld", wb_vld, 1);
      check("hold_quot", wb_quot, q);
      check("hold_rem", wb_rem, r);
    end
    wb_grant = 1'b1;
    step();
    wb_grant = 1'b0;
    check("idle_after_grant", no_op, 1);
    check("vld_after_grant", wb_vld, 0);
  endtask

  initial begin
    int seen;
    #1;
    check("rst_vld", wb_vld, 0);
    check("rst_quot", wb_quot, 0);
    check("rst_fflags", wb_fflags, 0);
    check("rst_no_op", no_op, 1);
    check("rst_rdy", ex1_start_rdy, 1);
    check("rst_stall", ex1_stall, 0);
    step();
    cpurst_b = 1'b1;
    step();

    start(1'b0, 200, 7, 3);   finish(1'b0, 200, 7, 3, 0);
    start(1'b1, 200, 0, 4);   finish(1'b1, 200, 0, 4, 0);
    start(1'b1, 81, 0, 5);    finish(1'b1, 81, 0, 5, 1);
    start(1'b0, 100, 0, 6);   finish(1'b0, 100, 0, 6, 0);
    start(1'b0, 255, 1, 7);   finish(1'b0, 255, 1, 7, 0);
    start(1'b1, 255, 9, 8);   finish(1'b1, 255, 9, 8, 0);

    // Grant held off while a second request waits behind the result.
    start(1'b0, 77, 5, 9);
    seen = 1;
    while (!wb_vld && seen < 40) begin step(); seen++; end
    check("hold_lat", seen, W + 1);
    ex1_start_vld  = 1'b1;
    ex1_start_sqrt = 1'b1;
    ex1_src0       = 8'd144;
    ex1_dst_freg   = 5'd10;
    #1;
    check("stall_in_wb", ex1_stall, 1);
    repeat (3) begin
      step();
      check("held_quot", wb_quot, 15);
      check("held_rem", wb_rem, 2);
      check("held_stall", ex1_stall, 1);
    end
    wb_grant = 1'b1;
    #1;
    check("rdy_at_grant", ex1_start_rdy, 0);
    step();
    wb_grant = 1'b0;
    check("rdy_after_grant", ex1_start_rdy, 1);
    check("stall_after_grant", ex1_stall, 0);
    step();
    ex1_start_vld = 1'b0;
    check("accepted_after_grant", no_op, 0);
    finish(1'b1, 144, 0, 10, 0);

    // Flush in the third CALC cycle.
    start(1'b0, 200, 7, 11);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle", no_op, 1);
    seen = 0;
    repeat (12) begin
      if (wb_vld) seen = 1;
      step();
    end
    check("flush_no_vld", seen, 0);

    // Flush coinciding with a start is not accepted.
    ex1_start_vld = 1'b1;
    flush         = 1'b1;
    step();
    ex1_start_vld = 1'b0;
    flush         = 1'b0;
    check("flush_start_rejected", no_op, 1);

    // Asynchronous reset mid-CALC clears a previously written-back result.
    start(1'b0, 13, 4, 12);
    step();
    step();
    cpurst_b = 1'b0;
    #1;
    check("arst_vld", wb_vld, 0);
    check("arst_quot", wb_quot, 0);
    check("arst_rem", wb_rem, 0);
    check("arst_freg", wb_freg, 0);
    check("arst_no_op", no_op, 1);
    check("arst_rdy", ex1_start_rdy, 1);
    step();
    cpurst_b = 1'b1;
    step();

    for (int i = 0; i < 40; i++) begin
      bit sq;
      int a, b, tag, g;
      sq  = 1'($urandom);
      a   = int'($urandom_range(0, 255));
      b   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      tag = int'($urandom_range(0, 31));
      g   = int'($urandom_range(0, 2));
      start(sq, a, b, tag);
      finish(sq, a, b, tag, g);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
